// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage: memory-access stage of the 5-stage RV32I pipeline.
//   Issues byte/half/word loads and stores on a req/ready data-memory port.
//   Stalls upstream while an access is outstanding and resolves taken
//   branches. Also holds the MEM/WB pipeline register.
//
// Ports
//   clk, reset                     clock (rising edge), async active-high reset
//   w_reg, branch, isbranch        EX/MEM control bits
//   w_dm[1:0], r_dm[2:0]           store size / load type
//   reg_dest[1:0], rd[4:0]         write-back select / destination register
//   pc_4, alu_result, pc_branch,   PC+4, effective address, branch target,
//   data2                          store data
//   dm_req, dm_we, dm_addr,        data-memory request port (combinational)
//   dm_be, dm_wdata
//   dm_rdata, dm_ready             data-memory response
//   stall, pc_sel, pc_target       pipeline control (combinational)
//   misalign_err                   misaligned access trap (combinational)
//   *_wb                           MEM/WB pipeline register
//
// Build option
//   MEM_MISALIGN_TRAP_EN  defined: misaligned accesses raise misalign_err, are
//                         not issued and write back nothing.
//                         undefined: low address bits are ignored and the
//                         access is aligned down.
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        w_reg,
    input  logic        branch,
    input  logic        isbranch,
    input  logic [1:0]  w_dm,
    input  logic [2:0]  r_dm,
    input  logic [1:0]  reg_dest,
    input  logic [4:0]  rd,
    input  logic [31:0] pc_4,
    input  logic [31:0] alu_result,
    input  logic [31:0] pc_branch,
    input  logic [31:0] data2,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ready,
    output logic        stall,
    output logic        pc_sel,
    output logic [31:0] pc_target,
    output logic        misalign_err,
    output logic        w_reg_wb,
    output logic [1:0]  reg_dest_wb,
    output logic [4:0]  rd_wb,
    output logic [31:0] alu_result_wb,
    output logic [31:0] load_data_wb,
    output logic [31:0] pc_4_wb
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_load_buf;

    logic              w_is_store;
    logic              w_is_load;
    logic              w_mem_op;
    logic              w_trap;
    logic              w_req;
    logic              w_stall;
    logic              w_req_g;
    logic              w_stall_g;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_load_data;

    // Operation decode; a store wins over a simultaneous load encoding.
    assign w_is_store = (w_dm != 2'b00);
    assign w_is_load  = ~w_is_store && (r_dm >= 3'd1) && (r_dm <= 3'd5);
    assign w_mem_op   = w_is_store | w_is_load;

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misalign;

    // Halves need an even address, words a 4-byte aligned one.
    always_comb begin
        w_misalign = 1'b0;
        if (w_is_store) begin
            case (w_dm)
                2'b10:   w_misalign = alu_result[0];
                2'b11:   w_misalign = |alu_result[1:0];
                default: w_misalign = 1'b0;
            endcase
        end else if (w_is_load) begin
            case (r_dm)
                3'd2, 3'd5: w_misalign = alu_result[0];
                3'd3:       w_misalign = |alu_result[1:0];
                default:    w_misalign = 1'b0;
            endcase
        end
    end

    assign w_trap = w_mem_op & w_misalign;
`else
    assign w_trap = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op && !w_trap) begin
                    w_state_nxt = dm_ready ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (dm_ready) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: request and stall while the access is outstanding.
    always_comb begin
        w_req   = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op && !w_trap) begin
                    w_req   = 1'b1;
                    w_stall = 1'b1;
                end
            end
            S_WAIT: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
            end
            default: begin
                w_req   = 1'b0;
                w_stall = 1'b0;
            end
        endcase
    end

    // Reset masks the combinational controls so an in-flight request drops at once.
    assign w_req_g      = w_req & ~reset;
    assign w_stall_g    = w_stall & ~reset;

    assign dm_req       = w_req_g;
    assign dm_we        = w_req_g & w_is_store;
    assign dm_addr      = {alu_result[31:2], 2'b00};
    assign dm_be        = w_be;
    assign dm_wdata     = w_wdata;
    assign stall        = w_stall_g;
    assign pc_sel       = branch & isbranch & ~w_stall_g;
    assign pc_target    = pc_branch;
    assign misalign_err = w_trap & ~reset;

    // Byte enables and lane-replicated store data.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = '0;
        if (w_is_store) begin
            case (w_dm)
                2'b01: begin
                    w_be    = 4'b0001 << alu_result[1:0];
                    w_wdata = {4{data2[7:0]}};
                end
                2'b10: begin
                    w_be    = alu_result[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{data2[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = data2;
                end
            endcase
        end else if (w_is_load) begin
            w_be = 4'b1111;
        end
    end

    // Load buffer, captured on the handshake edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_load_buf <= '0;
        end else if (w_req_g && dm_ready && w_is_load) begin
            r_load_buf <= dm_rdata;
        end
    end

    // Lane extraction and sign/zero extension from the load buffer.
    always_comb begin
        case (alu_result[1:0])
            2'd0:    w_byte = r_load_buf[7:0];
            2'd1:    w_byte = r_load_buf[15:8];
            2'd2:    w_byte = r_load_buf[23:16];
            default: w_byte = r_load_buf[31:24];
        endcase
        w_half      = alu_result[1] ? r_load_buf[31:16] : r_load_buf[15:0];
        w_load_data = '0;
        if (w_is_load) begin
            case (r_dm)
                3'd1:    w_load_data = {{24{w_byte[7]}}, w_byte};
                3'd2:    w_load_data = {{16{w_half[15]}}, w_half};
                3'd3:    w_load_data = r_load_buf;
                3'd4:    w_load_data = {24'd0, w_byte};
                3'd5:    w_load_data = {16'd0, w_half};
                default: w_load_data = '0;
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, trapped ops write nothing back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_reg_wb      <= 1'b0;
            reg_dest_wb   <= 2'b00;
            rd_wb         <= 5'd0;
            alu_result_wb <= '0;
            load_data_wb  <= '0;
            pc_4_wb       <= '0;
        end else if (w_stall_g) begin
            w_reg_wb      <= 1'b0;
        end else begin
            w_reg_wb      <= w_reg & ~w_trap;
            reg_dest_wb   <= reg_dest;
            rd_wb         <= rd;
            alu_result_wb <= alu_result;
            load_data_wb  <= w_trap ? '0 : w_load_data;
            pc_4_wb       <= pc_4;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage: randomized self-checking bench for mem_stage.
//   A small word-array memory model supplies load data and absorbs stores;
//   expected bus signals, stall length and MEM/WB contents are computed from
//   the instruction with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        w_reg, branch, isbranch;
    logic [1:0]  w_dm;
    logic [2:0]  r_dm;
    logic [1:0]  reg_dest;
    logic [4:0]  rd;
    logic [31:0] pc_4, alu_result, pc_branch, data2;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata, dm_rdata;
    logic        dm_ready;
    logic        stall, pc_sel;
    logic [31:0] pc_target;
    logic        misalign_err;
    logic        w_reg_wb;
    logic [1:0]  reg_dest_wb;
    logic [4:0]  rd_wb;
    logic [31:0] alu_result_wb, load_data_wb, pc_4_wb;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem_model [16];

    mem_stage dut (
        .clk(clk), .reset(reset),
        .w_reg(w_reg), .branch(branch), .isbranch(isbranch),
        .w_dm(w_dm), .r_dm(r_dm), .reg_dest(reg_dest), .rd(rd),
        .pc_4(pc_4), .alu_result(alu_result), .pc_branch(pc_branch), .data2(data2),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .stall(stall), .pc_sel(pc_sel), .pc_target(pc_target),
        .misalign_err(misalign_err),
        .w_reg_wb(w_reg_wb), .reg_dest_wb(reg_dest_wb), .rd_wb(rd_wb),
        .alu_result_wb(alu_result_wb), .load_data_wb(load_data_wb), .pc_4_wb(pc_4_wb)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic is_load_f(input logic [1:0] wd, input logic [2:0] rm);
        return (wd == 2'd0) && (rm >= 3'd1) && (rm <= 3'd5);
    endfunction

    function automatic logic misal_f(input logic [1:0] wd, input logic [2:0] rm,
                                     input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        if (wd == 2'd2) return a[0];
        if (wd == 2'd3) return a[1:0] != 2'd0;
        if (wd == 2'd0 && (rm == 3'd2 || rm == 3'd5)) return a[0];
        if (wd == 2'd0 && rm == 3'd3) return a[1:0] != 2'd0;
        return 1'b0;
`else
        return 1'b0 & a[0] & wd[0] & rm[0];
`endif
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] wd, input logic [2:0] rm,
                                          input logic [31:0] a);
        if (wd == 2'd1) return 4'd1 << a[1:0];
        if (wd == 2'd2) return 4'd3 << (2 * a[1]);
        if (wd == 2'd3) return 4'hF;
        if (is_load_f(wd, rm)) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] wd, input logic [31:0] d);
        if (wd == 2'd1) return 32'(d[7:0]) * 32'h0101_0101;
        if (wd == 2'd2) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] rm, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (rm)
            3'd1:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd2:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd3:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    // One instruction through the stage: hold inputs while stalled, then check MEM/WB.
    task automatic run_op(input logic wr, input logic [1:0] wd, input logic [2:0] rm,
                          input logic [31:0] a, input logic [31:0] d2,
                          input logic br, input logic ib, input logic [31:0] pcb,
                          input int waits);
        logic [31:0] word, exp_ld, wdat;
        logic [3:0]  be;
        logic [4:0]  e_rd;
        logic [1:0]  e_rdest;
        logic [31:0] e_pc4;
        logic        ld, mem, trap;
        int          k, stalls, exp_stalls;
        w_reg = wr; w_dm = wd; r_dm = rm; alu_result = a; data2 = d2;
        branch = br; isbranch = ib; pc_branch = pcb;
        e_rd = 5'($urandom); e_rdest = 2'($urandom); e_pc4 = $urandom;
        rd = e_rd; reg_dest = e_rdest; pc_4 = e_pc4;
        word   = mem_model[a[5:2]];
        ld     = is_load_f(wd, rm);
        mem    = (wd != 2'd0) || ld;
        trap   = mem && misal_f(wd, rm, a);
        exp_ld = (ld && !trap) ? exp_load(rm, a, word) : 32'd0;
        be     = exp_be(wd, rm, a);
        wdat   = exp_wdata(wd, d2);
        dm_rdata = ld ? word : $urandom;
        exp_stalls = (mem && !trap) ? waits + 1 : 0;
        k = 0;
        stalls = 0;
        forever begin
            dm_ready = (k >= waits);
            #1;
            if (k == 0) begin
                chk("misalign_err", 32'(misalign_err), 32'(trap));
                chk("dm_req", 32'(dm_req), 32'(mem && !trap));
                if (mem && !trap) begin
                    chk("dm_we", 32'(dm_we), 32'(wd != 2'd0));
                    chk("dm_be", 32'(dm_be), 32'(be));
                    chk("dm_addr", dm_addr, a & 32'hFFFF_FFFC);
                    if (wd != 2'd0) chk("dm_wdata", dm_wdata, wdat);
                end
            end else begin
                chk("wb_bubble", 32'(w_reg_wb), 32'd0);
            end
            if (!stall) break;
            stalls++;
            if (stalls > 20) begin
                chk("stall_timeout", 32'(stalls), 32'(exp_stalls));
                break;
            end
            @(posedge clk); #1;
            k++;
        end
        if (stalls > 0) chk("done_req", 32'(dm_req), 32'd0);
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        chk("pc_sel", 32'(pc_sel), 32'(br && ib));
        chk("pc_target", pc_target, pcb);
        @(posedge clk); #1;
        chk("w_reg_wb", 32'(w_reg_wb), 32'(wr && !trap));
        chk("reg_dest_wb", 32'(reg_dest_wb), 32'(e_rdest));
        chk("rd_wb", 32'(rd_wb), 32'(e_rd));
        chk("alu_result_wb", alu_result_wb, a);
        chk("pc_4_wb", pc_4_wb, e_pc4);
        chk("load_data_wb", load_data_wb, exp_ld);
        if (wd != 2'd0 && !trap) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_model[a[5:2]][8*i +: 8] = wdat[8*i +: 8];
            end
        end
    endtask

    task automatic drive_nop();
        w_reg = 1'b0; branch = 1'b0; isbranch = 1'b0; w_dm = 2'd0; r_dm = 3'd0;
        reg_dest = 2'd0; rd = 5'd0; pc_4 = 32'd0; alu_result = 32'd0;
        pc_branch = 32'd0; data2 = 32'd0; dm_rdata = 32'd0; dm_ready = 1'b0;
    endtask

    int          kind;
    logic [1:0]  r_wd;
    logic [2:0]  r_rm;
    logic        r_br, r_ib;

    initial begin
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        drive_nop();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dm_req", 32'(dm_req), 32'd0);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_pc_sel", 32'(pc_sel), 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        chk("rst_w_reg_wb", 32'(w_reg_wb), 32'd0);
        chk("rst_load_data_wb", load_data_wb, 32'd0);
        chk("rst_alu_result_wb", alu_result_wb, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        run_op(1'b0, 2'd3, 3'd0, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 0);
        mem_model[0] = 32'h80FF_0000;
        run_op(1'b1, 2'd0, 3'd1, 32'h203, 32'd0, 1'b0, 1'b0, 32'd0, 0);
        chk("plan_lb", load_data_wb, 32'hFFFF_FF80);
        run_op(1'b1, 2'd0, 3'd4, 32'h203, 32'd0, 1'b0, 1'b0, 32'd0, 1);
        chk("plan_lbu", load_data_wb, 32'h0000_0080);
        run_op(1'b1, 2'd0, 3'd2, 32'h202, 32'd0, 1'b0, 1'b0, 32'd0, 0);
        chk("plan_lh", load_data_wb, 32'hFFFF_80FF);
        mem_model[1] = 32'h1234_5678;
        run_op(1'b1, 2'd0, 3'd3, 32'h104, 32'd0, 1'b0, 1'b0, 32'd0, 3);
        chk("plan_lw", load_data_wb, 32'h1234_5678);
        run_op(1'b1, 2'd2, 3'd0, 32'h101, 32'h0000_A5C3, 1'b0, 1'b0, 32'd0, 0);
        run_op(1'b1, 2'd0, 3'd0, 32'h0, 32'd0, 1'b1, 1'b1, 32'h400, 0);
        run_op(1'b1, 2'd0, 3'd0, 32'h0, 32'd0, 1'b1, 1'b0, 32'h400, 0);
        run_op(1'b1, 2'd0, 3'd7, 32'h108, 32'd0, 1'b0, 1'b0, 32'h0, 0);

        // Reset while waiting on memory drops the request immediately.
        w_reg = 1'b1; r_dm = 3'd3; alu_result = 32'h100; dm_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("wait_stall", 32'(stall), 32'd1);
        chk("wait_req", 32'(dm_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_dm_req", 32'(dm_req), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_w_reg_wb", 32'(w_reg_wb), 32'd0);
        chk("arst_load_data_wb", load_data_wb, 32'd0);
        drive_nop();
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("arst_idle_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;

        // Randomized instruction mix.
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 3);
            r_wd = 2'd0; r_rm = 3'd0; r_br = 1'b0; r_ib = 1'b0;
            case (kind)
                0: r_wd = 2'($urandom_range(1, 3));
                1: r_rm = 3'($urandom_range(0, 7));
                2: begin
                    r_br = 1'($urandom);
                    r_ib = 1'($urandom);
                end
                default: r_rm = 3'($urandom_range(1, 5));
            endcase
            run_op(1'($urandom), r_wd, r_rm, 32'h100 + 32'($urandom_range(0, 63)),
                   $urandom, r_br, r_ib, $urandom, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RV32I pipeline, directly downstream of the EX/MEM pipeline register and upstream of write-back. It performs byte/half/word loads and stores against an external data-memory port with a req/ready handshake, stalls the pipeline while an access is outstanding, resolves taken branches, and holds the MEM/WB pipeline register.

## Interface
- No parameters.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- w_reg, branch, isbranch  in  1 each  from EX/MEM: reg-write enable, branch instruction, branch condition true.
- w_dm  in  2  store size: 00 none, 01 SB, 10 SH, 11 SW.
- r_dm  in  3  load type: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110/111 treated as none.
- reg_dest  in  2  write-back mux select, passed through.
- rd  in  5  destination register.
- pc_4, alu_result, pc_branch, data2  in  32 each  PC+4, ALU result/effective address, branch target, store data.
- dm_req  out  1  memory request.
- dm_we  out  1  1 = store.
- dm_addr  out  32  word address, {alu_result[31:2], 2'b00}.
- dm_be  out  4  byte enables.
- dm_wdata  out  32  store data, lane-replicated.
- dm_rdata  in  32  load data, valid when dm_ready.
- dm_ready  in  1  completes the access when high with dm_req.
- stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM.
- pc_sel  out  1  taken branch; fetch loads pc_target and upstream registers flush.
- pc_target  out  32  pc_branch.
- misalign_err  out  1  misaligned access detected (see Configuration).
- w_reg_wb, reg_dest_wb[1:0], rd_wb[4:0], alu_result_wb[31:0], load_data_wb[31:0], pc_4_wb[31:0]  out  MEM/WB register.

## Operation
- mem_op = (w_dm != 0) | (r_dm in 001..101); store takes priority if both set (dm_we=1).
- Misaligned: half at odd address, word with alu_result[1:0] != 0.
- FSM states IDLE, WAIT, DONE.
  - IDLE: aligned mem_op -> dm_req=1, stall=1; if dm_ready same cycle -> DONE, else -> WAIT. No mem_op or misaligned -> stay IDLE, no request.
  - WAIT: dm_req=1, stall=1; dm_ready -> DONE.
  - DONE: dm_req=0, stall=0; -> IDLE next edge.
- dm_rdata captured into an internal load buffer on the handshake edge.
- Store: SB be=0001<<a[1:0], wdata={4{data2[7:0]}}; SH be=0011<<a[1:0] (a[1] used), wdata={2{data2[15:0]}}; SW be=1111, wdata=data2. Loads: dm_be=1111, dm_we=0.
- Load extract from buffer by a[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
- pc_sel = branch & isbranch & ~stall; pc_target = pc_branch.
- MEM/WB update each edge: stall=1 -> bubble (w_reg_wb=0, other fields hold); else capture w_reg (0 if misalign_err), reg_dest, rd, alu_result, pc_4, extracted load data (0 for non-loads).

## Timing
- Reset: FSM IDLE; dm_req, dm_we, stall, pc_sel, misalign_err = 0; all MEM/WB outputs and load buffer 0. Reset mid-access drops dm_req immediately (async) without waiting for dm_ready.
- dm_*, stall, pc_sel combinational from FSM state and EX/MEM inputs.
- Non-memory op: 0 stall cycles; MEM/WB valid 1 edge later.
- Memory op with zero-wait memory (dm_ready=1 always): 1 stall cycle, MEM/WB valid 2 edges after entry. Each extra dm_ready-low cycle adds one stall cycle.
- dm_ready while dm_req=0 is ignored.
- Branch and memory op never coincide (branches carry w_dm=0, r_dm=0).

## Configuration
- MEM_MISALIGN_TRAP_EN defined: misaligned access raises misalign_err combinationally for that cycle, issues no request, no stall, writes back nothing (w_reg_wb=0).
- Undefined: misalign_err tied 0; half address bit 0 and word bits[1:0] ignored (access aligned down), executed normally.

## Test plan
- Reset during WAIT with dm_ready=0 -> dm_req, stall drop at once; all outputs 0; FSM IDLE.
- SW data2=0xDEADBEEF addr 0x100, dm_ready=1 -> one cycle dm_req=1, dm_we=1, dm_be=1111, dm_addr=0x100; stall high 1 cycle; w_reg_wb=0.
- LB addr 0x203, dm_rdata=0x80FF_0000 -> load_data_wb=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x202 -> 0xFFFF80FF.
- LW with dm_ready low 3 cycles -> stall high 4 cycles, w_reg_wb=0 during them, then load_data_wb=dm_rdata, w_reg_wb=1.
- SH addr 0x101: with MEM_MISALIGN_TRAP_EN -> misalign_err=1, dm_req=0, stall=0; without -> be=0011, dm_addr=0x100.
- branch=1, isbranch=1, pc_branch=0x400 -> pc_sel=1, pc_target=0x400; isbranch=0 -> pc_sel=0.
